// File: rtl/wb_commit_queue_pkg.sv
// Shared definitions for the write-back commit queue: entry layout helpers
// and the hard-wired zero register.
package wb_commit_queue_pkg;

  // Register 0 reads as zero; writes to it are discarded.
  localparam int unsigned REG_ZERO = 0;

  // A queue entry is {addr, data}: data in the low bits, address above it.
  function automatic int unsigned entry_w(input int unsigned aw, input int unsigned dw);
    return aw + dw;
  endfunction

  // Bit offset of the address field inside an entry.
  function automatic int unsigned addr_lsb(input int unsigned dw);
    return dw;
  endfunction

endpackage

// File: rtl/wb_commit_queue_if.sv
// Result channels from MEM/WB into the commit queue. Channel i occupies
// bits [i*AW +: AW] of ch_addr and [i*DW +: DW] of ch_data.
interface wb_commit_queue_if #(
  parameter int unsigned DW  = 32,
  parameter int unsigned AW  = 5,
  parameter int unsigned NCH = 2
);
  logic [NCH-1:0]    ch_valid;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH*DW-1:0] ch_data;
  logic              ch_ready;

  modport master (output ch_valid, output ch_addr, output ch_data, input ch_ready);
  modport slave  (input ch_valid, input ch_addr, input ch_data, output ch_ready);
endinterface

// File: rtl/wb_commit_queue_fifo.sv
// Circular buffer for the commit queue. Up to NCH entries are written per
// cycle, packed contiguously from the tail; one entry is read from the head.
// Storage, read pointer and occupancy are exposed for the bypass scan.
// The caller never pushes more than the free space or pops when empty.
module wb_commit_queue_fifo
  import wb_commit_queue_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned NCH   = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NCH-1:0]                        push_en,
  input  logic [NCH*AW-1:0]                     push_addr,
  input  logic [NCH*DW-1:0]                     push_data,
  input  logic                                  pop,
  output logic [AW-1:0]                         head_addr,
  output logic [DW-1:0]                         head_data,
  output logic [$clog2(DEPTH)-1:0]              rd_ptr,
  output logic [$clog2(DEPTH+1)-1:0]            count,
  output logic [DEPTH*entry_w(AW, DW)-1:0]      mem_flat
);

  localparam int unsigned EW       = entry_w(AW, DW);
  localparam int unsigned ADDR_LSB = addr_lsb(DW);
  localparam int unsigned PW       = $clog2(DEPTH);
  localparam int unsigned CW       = $clog2(DEPTH + 1);

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] n_push;

  // Pack the enabled channels into consecutive slots starting at the tail;
  // lower channel index lands first (older).
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    n_push   = {CW{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      if (push_en[i]) begin
        mem_d[wr_ptr_d] = {push_addr[i*AW +: AW], push_data[i*DW +: DW]};
        wr_ptr_d        = wr_ptr_d + PW'(1'b1);
        n_push          = n_push + CW'(1'b1);
      end else begin
        n_push = n_push;
      end
    end
  end

  // Advance the head on pop and track occupancy (pointers wrap modulo DEPTH).
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + n_push;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1'b1);
      count_d  = count_q + n_push - CW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Storage, pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {EW{1'b0}};
      end
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_addr = mem_q[rd_ptr_q][ADDR_LSB +: AW];
  assign head_data = mem_q[rd_ptr_q][DW-1:0];
  assign rd_ptr    = rd_ptr_q;
  assign count     = count_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign mem_flat[g*EW +: EW] = mem_q[g];
  end

endmodule

// File: rtl/wb_commit_queue.sv
// Write-back commit queue: accepts up to NCH results per cycle, drops
// writes to r0, drains one entry per cycle onto the register-file write
// port and offers a youngest-first bypass lookup over pending writes.
module wb_commit_queue
  import wb_commit_queue_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned NCH   = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           stall_in,
  wb_commit_queue_if.slave               ch,
  output logic                           rf_we,
  output logic [AW-1:0]                  rf_waddr,
  output logic [DW-1:0]                  rf_wdata,
  input  logic [AW-1:0]                  byp_addr,
  output logic                           byp_hit,
  output logic [DW-1:0]                  byp_data,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);

  localparam int unsigned EW       = entry_w(AW, DW);
  localparam int unsigned ADDR_LSB = addr_lsb(DW);
  localparam int unsigned PW       = $clog2(DEPTH);
  localparam int unsigned CW       = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] NCH_C   = CW'(NCH);
  localparam logic [AW-1:0] R0      = AW'(REG_ZERO);

  logic [1:0]          rst_sync_q, rst_sync_d;
  logic                rst_int_n;
  logic                rf_we_q, rf_we_d;
  logic [AW-1:0]       rf_waddr_q, rf_waddr_d;
  logic [DW-1:0]       rf_wdata_q, rf_wdata_d;
  logic [NCH-1:0]      push_en;
  logic                ready;
  logic                pop;
  logic [CW-1:0]       free_slots;
  logic [AW-1:0]       head_addr;
  logic [DW-1:0]       head_data;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       fifo_count;
  logic [DEPTH*EW-1:0] mem_flat;
  logic [PW-1:0]       scan_slot;
  logic [EW-1:0]       scan_ent;

  // Reset release is re-timed to clk; assertion reaches all state at once.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  // Two-stage reset synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_int_n = rst_sync_q[1];

  // Ready is all-or-nothing for NCH slots; r0 writes are accepted but not stored.
  always_comb begin
    free_slots = DEPTH_C - fifo_count;
    ready      = rst_int_n && !stall_in && (free_slots >= NCH_C);
    pop        = rst_int_n && !stall_in && (fifo_count != {CW{1'b0}});
    for (int i = 0; i < NCH; i++) begin
      push_en[i] = ready && ch.ch_valid[i] && (ch.ch_addr[i*AW +: AW] != R0);
    end
  end

  assign ch.ch_ready = ready;

  wb_commit_queue_fifo #(
    .DW    (DW),
    .AW    (AW),
    .NCH   (NCH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_int_n),
    .push_en   (push_en),
    .push_addr (ch.ch_addr),
    .push_data (ch.ch_data),
    .pop       (pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .rd_ptr    (rd_ptr),
    .count     (fifo_count),
    .mem_flat  (mem_flat)
  );

  // Load the popped head into the write port; otherwise drop we and hold addr/data.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (pop) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = head_addr;
      rf_wdata_d = head_data;
    end else begin
      rf_we_d = 1'b0;
    end
  end

  // Register-file write port registers.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= {AW{1'b0}};
      rf_wdata_q <= {DW{1'b0}};
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // Bypass: oldest source first so later (younger) matches override;
  // the rf port is oldest, then the queue from head to tail.
  always_comb begin
    byp_hit   = 1'b0;
    byp_data  = {DW{1'b0}};
    scan_slot = rd_ptr;
    scan_ent  = {EW{1'b0}};
    if (rf_we_q && (rf_waddr_q == byp_addr)) begin
      byp_hit  = 1'b1;
      byp_data = rf_wdata_q;
    end else begin
      byp_hit = 1'b0;
    end
    for (int k = 0; k < DEPTH; k++) begin
      scan_slot = rd_ptr + PW'(k);
      scan_ent  = mem_flat[int'(scan_slot)*EW +: EW];
      if ((CW'(k) < fifo_count) && (scan_ent[ADDR_LSB +: AW] == byp_addr)) begin
        byp_hit  = 1'b1;
        byp_data = scan_ent[DW-1:0];
      end else begin
        byp_hit = byp_hit;
      end
    end
    if (byp_addr == R0) begin
      byp_hit  = 1'b0;
      byp_data = {DW{1'b0}};
    end else begin
      byp_hit = byp_hit;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign count    = fifo_count;
  assign full     = (fifo_count == DEPTH_C);
  assign empty    = (fifo_count == {CW{1'b0}});

endmodule

// File: tb/tb_wb_commit_queue.sv
// Directed bench for wb_commit_queue with a queue-based reference model
// compared every cycle, plus literal expectations for key scenarios.
module tb_wb_commit_queue;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NCH = 2;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall_in = 1'b0;
  logic [AW-1:0] byp_addr = '0;
  logic rf_we, byp_hit, full, empty;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata, byp_data;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  wb_commit_queue_if #(.DW(DW), .AW(AW), .NCH(NCH)) chif ();

  wb_commit_queue #(.DW(DW), .AW(AW), .NCH(NCH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .ch(chif),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .byp_addr(byp_addr), .byp_hit(byp_hit), .byp_data(byp_data),
    .count(count), .full(full), .empty(empty)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending (addr,data) writes and the rf port.
  typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} ent_t;
  ent_t mq[$];
  logic m_we;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  bit m_rdy;
  ent_t m_h;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_we = 1'b0; m_waddr = '0; m_wdata = '0;
    end else begin
      m_rdy = !stall_in && ((DEPTH - mq.size()) >= NCH);
      if (!stall_in && mq.size() > 0) begin
        m_h = mq.pop_front();
        m_we = 1'b1; m_waddr = m_h.a; m_wdata = m_h.d;
      end else begin
        m_we = 1'b0;
      end
      if (m_rdy) begin
        for (int i = 0; i < NCH; i++) begin
          if (chif.ch_valid[i] && chif.ch_addr[i*AW +: AW] != '0)
            mq.push_back({chif.ch_addr[i*AW +: AW], chif.ch_data[i*DW +: DW]});
        end
      end
    end
  end

  function automatic logic [DW:0] model_byp(input logic [AW-1:0] a);
    if (a == '0) return '0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].a == a) return {1'b1, mq[i].d};
    if (m_we && m_waddr == a) return {1'b1, m_wdata};
    return '0;
  endfunction

  logic [DW:0] eb;
  // Per-cycle comparison against the model on the falling edge.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      eb = model_byp(byp_addr);
      chk("count", 64'(count), 64'(mq.size()));
      chk("empty", 64'(empty), 64'(mq.size() == 0));
      chk("full", 64'(full), 64'(mq.size() == DEPTH));
      chk("ch_ready", 64'(chif.ch_ready), 64'(!stall_in && ((DEPTH - mq.size()) >= NCH)));
      chk("rf_we", 64'(rf_we), 64'(m_we));
      chk("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
      chk("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
      chk("byp_hit", 64'(byp_hit), 64'(eb[DW]));
      chk("byp_data", 64'(byp_data), 64'(eb[DW-1:0]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NCH-1:0] v, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    chif.ch_valid = v;
    chif.ch_addr  = {a1, a0};
    chif.ch_data  = {d1, d0};
  endtask

  task automatic idle();
    drive(2'b00, '0, '0, '0, '0);
  endtask

  initial begin
    idle();
    // Reset state
    repeat (3) step();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_rf_we", 64'(rf_we), 64'd0);
    chk("rst_rf_waddr", 64'(rf_waddr), 64'd0);
    chk("rst_rf_wdata", 64'(rf_wdata), 64'd0);
    rst_n = 1'b1;
    repeat (3) step();
    chk_en = 1'b1;
    chk("ready_after_rst", 64'(chif.ch_ready), 64'd1);

    // Dual issue: r3 then r4, first write one edge after enqueue
    byp_addr = 5'd3;
    drive(2'b11, 5'd3, 32'h11, 5'd4, 32'h22);
    step();
    idle();
    chk("dual_count", 64'(count), 64'd2);
    chk("dual_model_size", 64'(mq.size()), 64'd2);
    chk("dual_we0", 64'(rf_we), 64'd0);
    chk("dual_byp", 64'({byp_hit, byp_data}), {31'd0, 1'b1, 32'h11});
    step();
    chk("dual_we1", 64'(rf_we), 64'd1);
    chk("dual_a1", 64'(rf_waddr), 64'd3);
    chk("dual_d1", 64'(rf_wdata), 64'h11);
    step();
    chk("dual_a2", 64'(rf_waddr), 64'd4);
    chk("dual_d2", 64'(rf_wdata), 64'h22);
    step();
    chk("dual_we_end", 64'(rf_we), 64'd0);
    chk("dual_hold", 64'(rf_waddr), 64'd4);

    // r0 filter
    drive(2'b11, 5'd0, 32'hFF, 5'd5, 32'h5);
    step();
    idle();
    chk("r0_count", 64'(count), 64'd1);
    step();
    chk("r0_addr", 64'(rf_waddr), 64'd5);
    chk("r0_data", 64'(rf_wdata), 64'h5);
    step();
    chk("r0_we_end", 64'(rf_we), 64'd0);

    // Back-pressure: count reaches 3, ready drops, one drain restores it
    drive(2'b11, 5'd1, 32'hA1, 5'd2, 32'hA2);
    step();
    drive(2'b11, 5'd6, 32'hA3, 5'd8, 32'hA4);
    step();
    chk("bp_count3", 64'(count), 64'd3);
    chk("bp_ready0", 64'(chif.ch_ready), 64'd0);
    drive(2'b11, 5'd9, 32'hBAD, 5'd10, 32'hBAD);
    step();
    idle();
    chk("bp_count2", 64'(count), 64'd2);
    chk("bp_ready1", 64'(chif.ch_ready), 64'd1);
    chk("bp_we_a", 64'(rf_waddr), 64'd2);
    repeat (4) step();

    // Random pushes across pointer wrap-around
    for (int n = 0; n < 20; n++) begin
      drive(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), $urandom,
            5'($urandom_range(0, 31)), $urandom);
      byp_addr = 5'($urandom_range(0, 31));
      stall_in = ($urandom_range(0, 4) == 0);
      step();
    end
    idle();
    stall_in = 1'b0;
    repeat (6) step();
    chk("rand_drained", 64'(count), 64'd0);

    // Stall for 3 cycles with 2 entries queued
    byp_addr = 5'd9;
    drive(2'b11, 5'd8, 32'hA, 5'd9, 32'hB);
    step();
    idle();
    stall_in = 1'b1;
    for (int s = 0; s < 3; s++) begin
      step();
      chk("stall_we", 64'(rf_we), 64'd0);
      chk("stall_count", 64'(count), 64'd2);
    end
    stall_in = 1'b0;
    step();
    chk("stall_a1", 64'({rf_we, rf_waddr, rf_wdata}), {26'd0, 1'b1, 5'd8, 32'hA});
    step();
    chk("stall_a2", 64'({rf_we, rf_waddr, rf_wdata}), {26'd0, 1'b1, 5'd9, 32'hB});
    step();
    chk("stall_end", 64'(rf_we), 64'd0);

    // Bypass: rf port (r7,0), queue (r7,1),(r7,2)
    drive(2'b01, 5'd7, 32'h0, 5'd0, 32'h0);
    step();
    drive(2'b11, 5'd7, 32'h1, 5'd7, 32'h2);
    step();
    idle();
    byp_addr = 5'd7;
    #1;
    chk("byp_rf", 64'({rf_we, rf_waddr, rf_wdata}), {26'd0, 1'b1, 5'd7, 32'h0});
    chk("byp_hit7", 64'(byp_hit), 64'd1);
    chk("byp_data7", 64'(byp_data), 64'h2);
    byp_addr = 5'd0;
    #1;
    chk("byp_r0", 64'({byp_hit, byp_data}), 64'd0);
    byp_addr = 5'd7;
    repeat (2) step();
    chk("byp_from_rf", 64'({byp_hit, byp_data}), {31'd0, 1'b1, 32'h2});
    step();
    chk("byp_miss", 64'({byp_hit, byp_data}), 64'd0);

    // Reset mid-drain with 3 entries queued
    drive(2'b11, 5'd10, 32'h1, 5'd11, 32'h2);
    step();
    drive(2'b11, 5'd12, 32'h3, 5'd13, 32'h4);
    step();
    idle();
    chk("md_count3", 64'(count), 64'd3);
    chk("md_we1", 64'(rf_we), 64'd1);
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("md_rst_we", 64'(rf_we), 64'd0);
    chk("md_rst_count", 64'(count), 64'd0);
    chk("md_rst_empty", 64'(empty), 64'd1);
    chk("md_rst_addr", 64'(rf_waddr), 64'd0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    chk_en = 1'b1;
    for (int s = 0; s < 4; s++) begin
      step();
      chk("md_no_write", 64'(rf_we), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
